// File: rtl/hash_uart_streamer.sv
// Serializes a latched hash digest toward the UART TX, one symbol per frame,
// optionally as lowercase hex with a CR LF trailer.
module hash_uart_streamer #(
  parameter int DIGEST_W    = 256,
  parameter int HEX_MODE    = 1,
  parameter int APPEND_CRLF = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIGEST_W-1:0] digest,
  input  logic                start,
  output logic                ready,
  output logic                done,
  output logic [7:0]          tx_data,
  output logic                tx_send,
  input  logic                tx_busy
);

  localparam int NDIG = (HEX_MODE != 0) ? DIGEST_W / 4 : DIGEST_W / 8;
  localparam int NSYM = NDIG + ((APPEND_CRLF != 0) ? 2 : 0);
  localparam int CW   = $clog2(NSYM + 1);
  localparam int SH   = (HEX_MODE != 0) ? 4 : 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DIGEST_W-1:0] sh_q, sh_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          dat_q, dat_d;
  logic                done_q, done_d;
  logic [DIGEST_W-1:0] sh_next;
  logic [CW-1:0]       cnt_next;

  // Symbol idx, where s already has that symbol's bits at the top
  function automatic logic [7:0] sym_f(
    input logic [DIGEST_W-1:0] s,
    input logic [CW-1:0]       idx
  );
    logic [3:0] nib;
    logic [7:0] r;
    nib = s[DIGEST_W-1 -: 4];
    if (idx < CW'(NDIG)) begin
      if (HEX_MODE != 0) begin
        r = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
                          : (8'h57 + {4'h0, nib});
      end else begin
        r = s[DIGEST_W-1 -: 8];
      end
    end else if (idx == CW'(NDIG)) begin
      r = 8'h0D;
    end else begin
      r = 8'h0A;
    end
    return r;
  endfunction

  assign sh_next  = sh_q << SH;
  assign cnt_next = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      dat_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    tx_send = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = digest;
          cnt_d   = '0;
          dat_d   = sym_f(digest, '0);
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_send = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (cnt_q == CW'(NSYM - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_next;
            sh_d    = sh_next;
            dat_d   = sym_f(sh_next, cnt_next);
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready   = (state_q == IDLE);
  assign done    = done_q;
  assign tx_data = dat_q;

endmodule

// File: tb/tb_hash_uart_streamer.sv
// Scoreboard bench: hex+CRLF instance (0) and raw instance (1) against
// behavioural TX models and a reference line encoder.
module tb_hash_uart_streamer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  start;
  logic [1:0]  ready;
  logic [1:0]  done;
  logic [1:0]  tx_send;
  logic [1:0]  tx_busy;
  logic [1:0]  force_busy;
  logic [7:0]  tx_data [2];
  logic [31:0] digest  [2];
  int          bcnt    [2];
  int          blen    [2];
  int          pend    [2];
  int          sent    [2];
  logic [7:0]  expq    [2][$];
  int          total;
  int          bad;

  hash_uart_streamer #(
    .DIGEST_W(32), .HEX_MODE(1), .APPEND_CRLF(1)
  ) u_hex (
    .clk(clk), .rst_n(rst_n), .digest(digest[0]), .start(start[0]),
    .ready(ready[0]), .done(done[0]), .tx_data(tx_data[0]),
    .tx_send(tx_send[0]), .tx_busy(tx_busy[0])
  );

  hash_uart_streamer #(
    .DIGEST_W(32), .HEX_MODE(0), .APPEND_CRLF(0)
  ) u_raw (
    .clk(clk), .rst_n(rst_n), .digest(digest[1]), .start(start[1]),
    .ready(ready[1]), .done(done[1]), .tx_data(tx_data[1]),
    .tx_send(tx_send[1]), .tx_busy(tx_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_busy[0] = force_busy[0] | (bcnt[0] != 0);
  assign tx_busy[1] = force_busy[1] | (bcnt[1] != 0);

  // UART TX stand-in: busy for blen cycles after each accepted strobe
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (tx_send[k] && bcnt[k] == 0) bcnt[k] <= blen[k];
      else if (bcnt[k] > 0) bcnt[k] <= bcnt[k] - 1;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: one digest -> expected line of bytes
  task automatic push_ref(int k, logic [31:0] d);
    int n;
    if (k == 0) begin
      for (int i = 0; i < 8; i++) begin
        n = int'((d >> (28 - 4 * i)) & 32'hF);
        expq[0].push_back(n < 10 ? 8'(48 + n) : 8'(97 + n - 10));
      end
      expq[0].push_back(8'h0D);
      expq[0].push_back(8'h0A);
    end else begin
      for (int i = 0; i < 4; i++)
        expq[1].push_back(8'((d >> (24 - 8 * i)) & 32'hFF));
    end
    pend[k]++;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (tx_send[k]) begin
          chk($sformatf("send_while_busy%0d", k), 32'(tx_busy[k]), 0);
          chk($sformatf("byte_expected%0d", k),
              32'(expq[k].size() != 0), 1);
          if (expq[k].size() != 0)
            chk($sformatf("byte%0d", k), 32'(tx_data[k]),
                32'(expq[k].pop_front()));
          sent[k]++;
        end
        if (done[k]) begin
          chk($sformatf("done_expected%0d", k), 32'(pend[k] != 0), 1);
          chk($sformatf("done_after_last%0d", k),
              32'(expq[k].size()), 0);
          chk($sformatf("done_busy_low%0d", k), 32'(tx_busy[k]), 0);
          if (pend[k] > 0) pend[k]--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(int k);
    int n = 0;
    while (!ready[k] && n < 5000) begin
      tick();
      n++;
    end
    chk($sformatf("ready_timeout%0d", k), 32'(ready[k]), 1);
  endtask

  task automatic wait_idle(int k);
    int n = 0;
    while ((pend[k] != 0 || !ready[k]) && n < 5000) begin
      tick();
      n++;
    end
    chk($sformatf("idle_timeout%0d", k), 32'(pend[k]), 0);
  endtask

  task automatic go(int k, logic [31:0] d);
    wait_ready(k);
    start[k]  = 1'b1;
    digest[k] = d;
    push_ref(k, d);
  endtask

  task automatic drop_start();
    tick();
    start     = 2'b00;
    digest[0] = $urandom;
    digest[1] = $urandom;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    start      = 2'b00;
    force_busy = 2'b00;
    digest[0]  = '0;
    digest[1]  = '0;
    blen[0]    = 20;
    blen[1]    = 20;
    pend[0]    = 0;
    pend[1]    = 0;
    sent[0]    = 0;
    sent[1]    = 0;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", 32'(ready[k]), 1);
      chk("rst_done", 32'(done[k]), 0);
      chk("rst_send", 32'(tx_send[k]), 0);
      chk("rst_data", 32'(tx_data[k]), 0);
    end
    rst_n = 1'b1;
    tick();

    // Known-answer lines on both flavours
    go(0, 32'hDEADBEEF);
    go(1, 32'h0123ABCD);
    tick();
    chk("latency_send0", 32'(tx_send[0]), 1);
    chk("latency_send1", 32'(tx_send[1]), 1);
    start     = 2'b00;
    digest[0] = $urandom;
    digest[1] = $urandom;
    wait_idle(0);
    wait_idle(1);
    chk("ready_back0", 32'(ready[0]), 1);

    // start hammered mid-stream must be ignored
    go(0, $urandom);
    drop_start();
    repeat (5) tick();
    for (int i = 0; i < 60; i++) begin
      start[0]  = 1'($urandom_range(0, 1));
      digest[0] = $urandom;
      tick();
    end
    start[0] = 1'b0;
    wait_idle(0);

    // Foreign transfer holds the line off
    force_busy[0] = 1'b1;
    repeat (50) tick();
    go(0, 32'hDEADBEEF);
    drop_start();
    repeat (10) begin
      chk("no_send_busy", 32'(tx_send[0]), 0);
      tick();
    end
    force_busy[0] = 1'b0;
    #2;
    chk("send_after_release", 32'(tx_send[0]), 1);
    chk("first_char_d", 32'(tx_data[0]), 32'h64);
    wait_idle(0);

    // Reset after the third strobe aborts the line
    go(0, $urandom);
    drop_start();
    base = sent[0];
    n    = 0;
    while (sent[0] < base + 3 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("three_sent", 32'(sent[0] - base), 3);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_send", 32'(tx_send[0]), 0);
    chk("abort_ready", 32'(ready[0]), 1);
    chk("abort_done", 32'(done[0]), 0);
    expq[0].delete();
    expq[1].delete();
    pend[0] = 0;
    pend[1] = 0;
    tick();
    rst_n = 1'b1;
    tick();
    go(0, 32'h0F1E2D3C);
    drop_start();
    wait_idle(0);

    // start in the done cycle begins the next line immediately
    go(0, $urandom);
    drop_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[0] && n < 5000);
    chk("done_seen", 32'(done[0]), 1);
    chk("ready_at_done", 32'(ready[0]), 1);
    #1;
    start[0]  = 1'b1;
    digest[0] = $urandom;
    push_ref(0, digest[0]);
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    #3;
    chk("b2b_send", 32'(tx_send[0]), 1);
    wait_idle(0);

    // Randomized lines with random TX frame lengths
    for (int r = 0; r < 6; r++) begin
      blen[0] = $urandom_range(1, 25);
      blen[1] = $urandom_range(1, 25);
      go(0, $urandom);
      go(1, $urandom);
      drop_start();
      wait_idle(0);
      wait_idle(1);
    end

    repeat (5) tick();
    chk("q_empty0", 32'(expq[0].size()), 0);
    chk("q_empty1", 32'(expq[1].size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
